// File: rtl/ecc_scrub_ctrl_pkg.sv
// Shared ECC definitions: codeword geometry and the scrub controller state set.
package ecc_scrub_ctrl_pkg;

  localparam int unsigned EccDataW = 32;
  localparam int unsigned EccParW  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StRdReq,
    StRdWait,
    StFault
  } scrub_state_e;

endpackage

// File: rtl/ecc_scrub_ctrl_parity.sv
// 16-bit load-path ECC check bits for a 32-bit word, purely combinational.
// Check bit i covers data[i], data[16+i] and data[16+((i+5) mod 16)].
module ecc_parity_gen
  import ecc_scrub_ctrl_pkg::*;
(
  input  logic [EccDataW-1:0] data_i,
  output logic [EccParW-1:0]  parity_o
);

  logic [EccParW-1:0] lo, hi, hi_rot;

  // Split the word and fold the upper half in twice, once rotated right by 5.
  always_comb begin
    lo       = data_i[EccParW-1:0];
    hi       = data_i[EccDataW-1:EccParW];
    hi_rot   = {hi[4:0], hi[EccParW-1:5]};
    parity_o = lo ^ hi ^ hi_rot;
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ECC scrub controller: writes back corrected words, re-reads on uncorrectable
// errors up to MAX_RETRY times, then raises a sticky fault until cleared.
module ecc_scrub_ctrl
  import ecc_scrub_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [EccDataW-1:0] corrected_data,
  input  logic                single_double_error,
  input  logic                triple_error,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                wr_req,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [EccDataW-1:0] wr_data,
  output logic [EccParW-1:0]  wr_parity,
  input  logic                wr_ack,
  output logic                stall,
  output logic                fault,
  output logic [ADDR_W-1:0]   fault_addr,
  input  logic                fault_clr,
  output logic [15:0]         scrub_count
);

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  scrub_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [EccDataW-1:0] data_q, data_d;
  logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
  logic [15:0]         scrub_count_q, scrub_count_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;

  // State and datapath registers; reset abandons any write-back or retry in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      data_q        <= '0;
      retry_q       <= '0;
      scrub_count_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      retry_q       <= retry_d;
      scrub_count_q <= scrub_count_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  // Next-state logic; triple_error always outranks single_double_error.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    retry_d       = retry_q;
    scrub_count_d = scrub_count_q;
    fault_addr_d  = fault_addr_q;
    retry_inc     = retry_q + RetryW'(1);

    unique case (state_q)
      StIdle: begin
        if (ld_valid && triple_error) begin
          addr_d  = ld_addr;
          retry_d = '0;
          state_d = StRdReq;
        end else if (ld_valid && single_double_error) begin
          addr_d  = ld_addr;
          data_d  = corrected_data;
          state_d = StWb;
        end
      end
      StWb: begin
        if (wr_ack) begin
          state_d = StIdle;
          if (scrub_count_q != 16'hFFFF) begin
            scrub_count_d = scrub_count_q + 16'd1;
          end
        end
      end
      StRdReq: begin
        state_d = StRdWait;
      end
      StRdWait: begin
        // Only the requested word comes back while stalled, so ld_addr is not checked.
        if (ld_valid) begin
          if (triple_error) begin
            retry_d = retry_inc;
            if (retry_inc == RetryW'(MAX_RETRY)) begin
              fault_addr_d = addr_q;
              state_d      = StFault;
            end else begin
              state_d = StRdReq;
            end
          end else if (single_double_error) begin
            data_d  = corrected_data;
            state_d = StWb;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFault: begin
        if (fault_clr) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register.
  always_comb begin
    rd_req      = (state_q == StRdReq);
    wr_req      = (state_q == StWb);
    fault       = (state_q == StFault);
    stall       = (state_q != StIdle);
    rd_addr     = addr_q;
    wr_addr     = addr_q;
    wr_data     = data_q;
    fault_addr  = fault_addr_q;
    scrub_count = scrub_count_q;
  end

  ecc_parity_gen u_parity_gen (
    .data_i   (data_q),
    .parity_o (wr_parity)
  );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Scoreboard bench for ecc_scrub_ctrl: episodes push expected events, a
// negedge monitor pops and compares them as the DUT presents requests.
module tb_ecc_scrub_ctrl;

  localparam int AW   = 10;
  localparam int MAXR = 3;

  localparam int K_CLEAN = 0;
  localparam int K_SDE   = 1;
  localparam int K_TE    = 2;
  localparam int K_BOTH  = 3;

  localparam int EV_RD    = 0;
  localparam int EV_WB    = 1;
  localparam int EV_FAULT = 2;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic [31:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid, single_double_error, triple_error, wr_ack, fault_clr;
  logic [AW-1:0] ld_addr;
  logic [31:0]   corrected_data;
  logic          rd_req, wr_req, stall, fault;
  logic [AW-1:0] rd_addr, wr_addr, fault_addr;
  logic [31:0]   wr_data;
  logic [15:0]   wr_parity, scrub_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  ev_t         exp_q[$];
  int          res_kind_q[$];
  logic [31:0] res_data_q[$];
  logic [15:0] model_count;
  logic        fault_prev = 1'b0;
  ev_t         mon_e;

  ecc_scrub_ctrl #(.ADDR_W(AW), .MAX_RETRY(MAXR)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ld_valid            (ld_valid),
    .ld_addr             (ld_addr),
    .corrected_data      (corrected_data),
    .single_double_error (single_double_error),
    .triple_error        (triple_error),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_parity           (wr_parity),
    .wr_ack              (wr_ack),
    .stall               (stall),
    .fault               (fault),
    .fault_addr          (fault_addr),
    .fault_clr           (fault_clr),
    .scrub_count         (scrub_count)
  );

  always #5 clk = ~clk;

  // Check bits built column by column: low data bit j feeds bit j; high bit
  // 16+k feeds bits k and (k+11) mod 16.
  function automatic logic [15:0] ref_parity(input logic [31:0] d);
    logic [15:0] p;
    p = '0;
    for (int j = 0; j < 32; j++) begin
      if (d[j]) begin
        if (j < 16) begin
          p[j] = ~p[j];
        end else begin
          p[j-16]          = ~p[j-16];
          p[(j - 16 + 11) % 16] = ~p[(j - 16 + 11) % 16];
        end
      end
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every request the DUT raises must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_req", 64'(1'b1), 64'(1'b0));
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_kind", 64'(mon_e.kind), 64'(EV_RD));
          check("rd_addr", 64'(rd_addr), 64'(mon_e.addr));
        end
      end
      if (wr_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_req", 64'(1'b1), 64'(1'b0));
        end else begin
          mon_e = exp_q[0];
          check("wr_kind", 64'(mon_e.kind), 64'(EV_WB));
          check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
          check("wr_data", 64'(wr_data), 64'(mon_e.data));
          check("wr_parity", 64'(wr_parity), 64'(ref_parity(mon_e.data)));
          check("wr_roundtrip_syndrome", 64'(ref_parity(wr_data) ^ wr_parity), 64'(16'h0));
          if (wr_ack) void'(exp_q.pop_front());
        end
      end
      if (fault && !fault_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fault", 64'(1'b1), 64'(1'b0));
        end else begin
          mon_e = exp_q.pop_front();
          check("fault_kind", 64'(mon_e.kind), 64'(EV_FAULT));
          check("fault_addr", 64'(fault_addr), 64'(mon_e.addr));
        end
      end
      fault_prev = fault;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ld_valid            = 1'b0;
    single_double_error = 1'b0;
    triple_error        = 1'b0;
    wr_ack              = 1'b0;
    fault_clr           = 1'b0;
  endtask

  // Random load traffic for states that must ignore ld_valid.
  task automatic junk_load();
    ld_valid            = 1'($urandom_range(0, 1));
    ld_addr             = AW'($urandom);
    corrected_data      = $urandom;
    single_double_error = 1'($urandom_range(0, 1));
    triple_error        = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_load(input int kind, input logic [AW-1:0] a, input logic [31:0] d);
    ld_valid            = 1'b1;
    ld_addr             = a;
    corrected_data      = d;
    single_double_error = 1'(kind == K_SDE || kind == K_BOTH);
    triple_error        = 1'(kind == K_TE || kind == K_BOTH);
  endtask

  task automatic gen_results();
    int r;
    for (int i = 0; i < MAXR; i++) begin
      r = $urandom_range(0, 7);
      res_kind_q.push_back(r < 2 ? K_CLEAN : (r < 4 ? K_SDE : (r < 6 ? K_TE : K_BOTH)));
      res_data_q.push_back($urandom);
    end
  endtask

  task automatic episode(input int kind, input logic [AW-1:0] addr, input logic [31:0] data,
                         input int wb_delay);
    int  n_used, outcome, retries, n;
    ev_t e;
    n_used  = 0;
    outcome = K_CLEAN;
    retries = 0;
    e.addr  = addr;
    e.data  = data;
    // Reference outcome from the error-handling rules.
    if (kind == K_SDE) begin
      e.kind = EV_WB;
      exp_q.push_back(e);
      outcome = K_SDE;
    end else if (kind == K_TE || kind == K_BOTH) begin
      for (int i = 0; i < res_kind_q.size(); i++) begin
        e.kind = EV_RD;
        exp_q.push_back(e);
        n_used++;
        if (res_kind_q[i] == K_CLEAN) break;
        if (res_kind_q[i] == K_SDE) begin
          e.kind = EV_WB;
          e.data = res_data_q[i];
          exp_q.push_back(e);
          outcome = K_SDE;
          break;
        end
        retries++;
        if (retries == MAXR) begin
          e.kind = EV_FAULT;
          exp_q.push_back(e);
          outcome = K_TE;
          break;
        end
      end
    end

    drive_load(kind, addr, data);
    tick();
    quiet();
    check("stall_after_detect", 64'(stall), 64'(kind != K_CLEAN));
    check("wr_req_after_detect", 64'(wr_req), 64'(kind == K_SDE));

    for (int i = 0; i < n_used; i++) begin
      n = 0;
      while (!rd_req && n < 20) begin
        tick();
        n++;
      end
      check("rd_req_seen", 64'(rd_req), 64'(1'b1));
      junk_load();
      tick();
      quiet();
      repeat ($urandom_range(0, 2)) tick();
      drive_load(res_kind_q[i], AW'($urandom), res_data_q[i]);
      tick();
      quiet();
    end

    if (outcome == K_SDE) begin
      n = 0;
      while (!wr_req && n < 20) begin
        tick();
        n++;
      end
      check("wr_req_seen", 64'(wr_req), 64'(1'b1));
      for (int d = 0; d < wb_delay; d++) begin
        junk_load();
        fault_clr = 1'($urandom_range(0, 1));
        tick();
      end
      quiet();
      wr_ack = 1'b1;
      tick();
      quiet();
      if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
    end else if (outcome == K_TE) begin
      n = 0;
      while (!fault && n < 20) begin
        tick();
        n++;
      end
      check("fault_seen", 64'(fault), 64'(1'b1));
      repeat ($urandom_range(0, 3)) begin
        junk_load();
        wr_ack = 1'($urandom_range(0, 1));
        tick();
      end
      quiet();
      check("fault_stall", 64'(stall), 64'(1'b1));
      check("fault_addr_hold", 64'(fault_addr), 64'(addr));
      fault_clr = 1'b1;
      tick();
      quiet();
    end

    check("end_stall", 64'(stall), 64'(1'b0));
    check("end_fault", 64'(fault), 64'(1'b0));
    check("scrub_count", 64'(scrub_count), 64'(model_count));
    check("events_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    res_kind_q.delete();
    res_data_q.delete();

    // Idle gap: clean loads and stray acks/clears must do nothing.
    ld_valid  = 1'($urandom_range(0, 1));
    ld_addr   = AW'($urandom);
    wr_ack    = 1'($urandom_range(0, 1));
    fault_clr = 1'($urandom_range(0, 1));
    tick();
    quiet();
    check("gap_stall", 64'(stall), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    quiet();
    ld_addr        = '0;
    corrected_data = '0;
    model_count    = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_rd_req", 64'(rd_req), 64'(1'b0));
    check("rst_wr_req", 64'(wr_req), 64'(1'b0));
    check("rst_stall", 64'(stall), 64'(1'b0));
    check("rst_fault", 64'(fault), 64'(1'b0));
    check("rst_scrub", 64'(scrub_count), 64'(16'h0));
    check("rst_fault_addr", 64'(fault_addr), 64'(0));
    check("rst_addr_latch", 64'(rd_addr), 64'(0));
    check("rst_data_latch", 64'(wr_data), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed scenarios.
    episode(K_SDE, AW'(10'h005), 32'hDEADBEEF, 3);
    res_kind_q.push_back(K_CLEAN);
    res_data_q.push_back(32'h0);
    episode(K_TE, AW'(10'h3FF), 32'h0, 0);
    for (int i = 0; i < MAXR; i++) begin
      res_kind_q.push_back(K_TE);
      res_data_q.push_back($urandom);
    end
    episode(K_TE, AW'(10'h155), 32'h0, 0);
    res_kind_q.push_back(K_CLEAN);
    res_data_q.push_back(32'h0);
    episode(K_BOTH, AW'(10'h0AA), 32'h12345678, 0);
    res_kind_q.push_back(K_SDE);
    res_data_q.push_back(32'hCAFEF00D);
    episode(K_TE, AW'(10'h2C3), 32'h0, 1);

    // Randomised episodes.
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind >= K_TE) gen_results();
      episode(kind, AW'($urandom), $urandom, $urandom_range(0, 3));
    end

    // Reset mid write-back: outputs drop without a clock edge, nothing retried.
    e.kind = EV_WB;
    e.addr = AW'(10'h111);
    e.data = 32'h0BADF00D;
    exp_q.push_back(e);
    drive_load(K_SDE, e.addr, e.data);
    tick();
    quiet();
    tick();
    check("pre_rst_wr_req", 64'(wr_req), 64'(1'b1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_wr_req", 64'(wr_req), 64'(1'b0));
    check("async_rst_stall", 64'(stall), 64'(1'b0));
    exp_q.delete();
    model_count = '0;
    tick();
    rst = 1'b0;
    check("post_rst_scrub", 64'(scrub_count), 64'(16'h0));
    wr_ack = 1'b1;
    tick();
    quiet();
    tick();
    check("abandoned_wr_req", 64'(wr_req), 64'(1'b0));
    check("abandoned_scrub", 64'(scrub_count), 64'(16'h0));

    // Saturation of the write-back counter.
    force dut.scrub_count_q = 16'hFFFF;
    tick();
    release dut.scrub_count_q;
    model_count = 16'hFFFF;
    check("preload_scrub", 64'(scrub_count), 64'(16'hFFFF));
    episode(K_SDE, AW'(10'h321), 32'hA5A5_5A5A, 1);
    check("sat_scrub", 64'(scrub_count), 64'(16'hFFFF));

    check("leftover_events", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
